// File: rtl/pdm_dac_tx.sv
// pdm_dac_tx: PCM-to-PDM audio output path.
// Signed 16-bit PCM samples arrive over a valid/ready handshake into a one-entry
// holding register, are upsampled by OSR and drive a 1-bit second-order
// delta-sigma modulator clocked by a divided PDM bit clock.
// Build option: define PDM_TX_INTERP_EN to ramp linearly from the previous to the
// current sample across each OSR-bit slot; left undefined, each sample is held
// for the whole slot and no previous-sample register exists.
module pdm_dac_tx #(
    parameter int DIV = 20,
    parameter int OSR = 128,
    parameter int W   = 24
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pcm_in,
    input  logic        pcm_valid,
    output logic        pcm_ready,
    output logic        pdm_clk,
    output logic        pdm_out,
    output logic        underrun
);

    localparam int CW = $clog2(DIV);
    localparam int KW = $clog2(OSR);
    localparam int SW = W + 2;

    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);
    localparam logic [KW-1:0] K_LAST   = KW'(OSR - 1);

    // Symmetric integrator rails; two guard bits keep the raw sums from wrapping.
    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = -SAT_MAX;
    localparam logic signed [SW-1:0] FB_POS  = SW'(32768);
    localparam logic signed [SW-1:0] FB_NEG  = -FB_POS;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic [KW-1:0]        k_q, k_d;
    logic                 pdm_clk_q;
    logic                 pdm_out_q;
    logic                 underrun_q;
    logic                 full_q;
    logic signed [15:0]   hold_q;
    logic signed [15:0]   cur_q;
    logic signed [W-1:0]  i1_q, i1_d;
    logic signed [W-1:0]  i2_q, i2_d;
    logic signed [W-1:0]  x_w;
    logic signed [SW-1:0] fb_w, sum1_w, sum2_w;
    logic                 bit_stb;
    logic                 sample_stb;
    logic                 accept;
    logic                 mod_bit;

    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            sat = W'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            sat = W'(SAT_MIN);
        end else begin
            sat = W'(v);
        end
    endfunction

    // Strobes and counter next-state values.
    always_comb begin
        bit_stb    = (cnt_q == CNT_LAST);
        sample_stb = bit_stb && (k_q == K_LAST);
        accept     = pcm_valid && !full_q;
        cnt_d      = bit_stb ? '0 : cnt_q + 1'b1;
        k_d        = (k_q == K_LAST) ? '0 : k_q + 1'b1;
    end

`ifdef PDM_TX_INTERP_EN
    localparam int XW = 16 + KW + 1;

    logic signed [15:0]   prev_q;
    logic signed [XW-1:0] prev_x, diff_x, k_x, ramp_x;
    logic signed [15:0]   x16;

    // Linear ramp prev -> cur across the slot, indexed by the bit position k.
    always_comb begin
        prev_x = {{(XW-16){prev_q[15]}}, prev_q};
        diff_x = {{(XW-16){cur_q[15]}}, cur_q} - prev_x;
        k_x    = {{(XW-KW){1'b0}}, k_q};
        ramp_x = (prev_x <<< KW) + diff_x * k_x;
        x16    = 16'(ramp_x >>> KW);
        x_w    = {{(W-16){x16[15]}}, x16};
    end

    // The outgoing sample becomes the start point of the next ramp.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= '0;
        end else if (sample_stb) begin
            prev_q <= cur_q;
        end
    end
`else
    // Zero-order hold: the current sample drives the modulator for the whole slot.
    always_comb begin
        x_w = {{(W-16){cur_q[15]}}, cur_q};
    end
`endif

    // Second-order modulator next state; i2 integrates the pre-update i1.
    always_comb begin
        mod_bit = ~i2_q[W-1];
        fb_w    = mod_bit ? FB_POS : FB_NEG;
        sum1_w  = {{2{i1_q[W-1]}}, i1_q} + {{2{x_w[W-1]}}, x_w} - fb_w;
        sum2_w  = {{2{i2_q[W-1]}}, i2_q} + {{2{i1_q[W-1]}}, i1_q} - fb_w;
        i1_d    = sat(sum1_w);
        i2_d    = sat(sum2_w);
    end

    // Bit timer and 50% duty PDM clock: low for the first half of each bit period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            pdm_clk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            if (cnt_q == '0) begin
                pdm_clk_q <= 1'b0;
            end else if (cnt_q == CNT_HALF) begin
                pdm_clk_q <= 1'b1;
            end
        end
    end

    // Position of the current bit within the OSR-bit sample slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q <= '0;
        end else if (bit_stb) begin
            k_q <= k_d;
        end
    end

    // Modulator state and PDM data register, updated once per bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q      <= '0;
            i2_q      <= '0;
            pdm_out_q <= 1'b0;
        end else if (bit_stb) begin
            i1_q      <= i1_d;
            i2_q      <= i2_d;
            pdm_out_q <= mod_bit;
        end
    end

    // Holding register: filled by the handshake, drained at each sample slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q     <= '0;
            cur_q      <= '0;
            full_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            underrun_q <= 1'b0;
            if (sample_stb) begin
                if (full_q) begin
                    cur_q  <= hold_q;
                    full_q <= 1'b0;
                end else begin
                    underrun_q <= 1'b1;
                end
            end
            // An accept coinciding with a slot only happens while empty, so it
            // simply refills the holding register for the following slot.
            if (accept) begin
                hold_q <= pcm_in;
                full_q <= 1'b1;
            end
        end
    end

    assign pcm_ready = ~full_q;
    assign pdm_clk   = pdm_clk_q;
    assign pdm_out   = pdm_out_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_pdm_dac_tx.sv
// tb_pdm_dac_tx: self-checking bench for pdm_dac_tx (DIV=20, OSR=128, W=24).
// A behavioural reference model (sample queue plus the modulator difference
// equations on plain integers) predicts every output each clock; density and
// handshake timing are also checked directly against the stated rules.
module tb_pdm_dac_tx;

    localparam int DIV     = 20;
    localparam int OSR     = 128;
    localparam int W       = 24;
    localparam int LOG_OSR = 7;
    localparam int SLOT    = OSR * DIV;
    localparam longint SAT_LIM = (longint'(1) <<< (W - 1)) - 1;

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic [15:0] pcm_in    = 16'h0000;
    logic        pcm_valid = 1'b0;
    logic        pcm_ready;
    logic        pdm_clk;
    logic        pdm_out;
    logic        underrun;

    pdm_dac_tx #(.DIV(DIV), .OSR(OSR), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pcm_in    (pcm_in),
        .pcm_valid (pcm_valid),
        .pcm_ready (pcm_ready),
        .pdm_clk   (pdm_clk),
        .pdm_out   (pdm_out),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state.
    int     t;
    int     hold_m[$];
    longint cur_m, prev_m, i1_m, i2_m;
    logic   e_out, e_clk, e_ready, e_under;
    int     dut_bits[$];

    function automatic longint sat(input longint v);
        if (v > SAT_LIM) return SAT_LIM;
        if (v < -SAT_LIM) return -SAT_LIM;
        return v;
    endfunction

    function automatic void model_reset();
        t = 0;
        hold_m.delete();
        cur_m = 0; prev_m = 0; i1_m = 0; i2_m = 0;
        e_out = 1'b0; e_clk = 1'b0; e_ready = 1'b1; e_under = 1'b0;
        dut_bits.delete();
    endfunction

    // Advance the model by one clock edge using the inputs presented before it.
    function automatic void model_step();
        bit     rdy_before;
        bit     bstb;
        bit     sstb;
        int     kk;
        longint x, fb, n1, n2;
        rdy_before = (hold_m.size() == 0);
        t++;
        bstb = (t % DIV == 0);
        sstb = 1'b0;
        e_under = 1'b0;
        if (bstb) begin
            kk = ((t / DIV) - 1) % OSR;
            sstb = (kk == OSR - 1);
`ifdef PDM_TX_INTERP_EN
            x = (prev_m * OSR + longint'(kk) * (cur_m - prev_m)) >>> LOG_OSR;
`else
            x = cur_m;
`endif
            e_out = (i2_m >= 0);
            fb = e_out ? 32768 : -32768;
            n1 = sat(i1_m + x - fb);
            n2 = sat(i2_m + i1_m - fb);
            i1_m = n1;
            i2_m = n2;
        end
        if (sstb) begin
            prev_m = cur_m;
            if (hold_m.size() > 0) cur_m = hold_m.pop_front();
            else e_under = 1'b1;
        end
        if (pcm_valid && rdy_before) hold_m.push_back(int'($signed(pcm_in)));
        e_ready = (hold_m.size() == 0);
        e_clk = (((t - 1) % DIV) >= DIV / 2);
    endfunction

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step();
        #1;
        if (rst_n && t > 0 && (t % DIV == 0)) dut_bits.push_back(int'(pdm_out));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        pcm_valid = 1'b0;
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic int count_ones(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi && i < dut_bits.size(); i++) c += dut_bits[i];
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 16; i++) begin
            pcm_in = 16'($urandom);
            pcm_valid = 1'($urandom);
            tick();
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== 4'b0010)
                $display("FAIL reset_hold: clk/out/rdy/und got %b want 0010",
                         {pdm_clk, pdm_out, pcm_ready, underrun});
            else n_pass++;
        end
        rst_n = 1'b1;
        pcm_valid = 1'b1;
        pcm_in = 16'($urandom);
        for (int i = 0; i < 35; i++) begin
            tick();
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== {e_clk, e_out, e_ready, e_under})
                $display("FAIL reset_run t=%0d: got %b want %b", t,
                         {pdm_clk, pdm_out, pcm_ready, underrun}, {e_clk, e_out, e_ready, e_under});
            else n_pass++;
        end
        n_checks++;
        if ({pdm_clk, pdm_out, pcm_ready} !== 3'b110)
            $display("FAIL pre_reset_state: clk/out/rdy got %b want 110", {pdm_clk, pdm_out, pcm_ready});
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({pdm_clk, pdm_out, pcm_ready, underrun} !== 4'b0010)
            $display("FAIL async_reset: got %b want 0010", {pdm_clk, pdm_out, pcm_ready, underrun});
        else n_pass++;
        model_reset();
        tick();
        n_checks++;
        if ({pdm_clk, pdm_out, pcm_ready, underrun} !== 4'b0010)
            $display("FAIL async_reset_hold: got %b want 0010", {pdm_clk, pdm_out, pcm_ready, underrun});
        else n_pass++;
    endtask

    task automatic test_timing();
        logic last;
        do_reset();
        pcm_valid = 1'b0;
        last = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== {e_clk, e_out, e_ready, e_under})
                $display("FAIL timing_model t=%0d: got %b want %b", t,
                         {pdm_clk, pdm_out, pcm_ready, underrun}, {e_clk, e_out, e_ready, e_under});
            else n_pass++;
            n_checks++;
            if (pdm_out !== last && (t % DIV) != 0)
                $display("FAIL timing_out_edge t=%0d: pdm_out moved to %b off the bit edge", t, pdm_out);
            else n_pass++;
            if (t == DIV) begin
                n_checks++;
                if (pdm_out !== 1'b1) $display("FAIL first_bit: got %b want 1", pdm_out);
                else n_pass++;
            end
            last = pdm_out;
        end
    endtask

    task automatic test_zero();
        int   acc_t[$];
        logic rdy_pre;
        int   ones;
        do_reset();
        pcm_in = 16'h0000;
        pcm_valid = 1'b1;
        for (int i = 0; i < 3 * SLOT + 5; i++) begin
            rdy_pre = pcm_ready;
            tick();
            if (rdy_pre) begin
                acc_t.push_back(t);
                $display("zero: accept t=%0d sample=0", t);
            end
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== {e_clk, e_out, e_ready, e_under})
                $display("FAIL zero_model t=%0d: got %b want %b", t,
                         {pdm_clk, pdm_out, pcm_ready, underrun}, {e_clk, e_out, e_ready, e_under});
            else n_pass++;
        end
        n_checks++;
        if (acc_t.size() !== 4) $display("FAIL zero_accept_count: got %0d want 4", acc_t.size());
        else n_pass++;
        for (int j = 0; j < acc_t.size() && j < 4; j++) begin
            n_checks++;
            if (acc_t[j] !== 1 + j * SLOT)
                $display("FAIL zero_accept_time[%0d]: got %0d want %0d", j, acc_t[j], 1 + j * SLOT);
            else n_pass++;
        end
        for (int s = 0; s + 256 <= dut_bits.size(); s += 32) begin
            ones = count_ones(s, s + 255);
            n_checks++;
            if (ones < 126 || ones > 130)
                $display("FAIL zero_window@%0d: ones got %0d want 128+/-2", s, ones);
            else n_pass++;
        end
    endtask

    task automatic test_density(input int val);
        int ones, exp1, exp2;
        do_reset();
        pcm_in = 16'(val);
        pcm_valid = 1'b1;
        $display("density: sample=%0d", val);
        for (int i = 0; i < 1280 * DIV; i++) begin
            tick();
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== {e_clk, e_out, e_ready, e_under})
                $display("FAIL density_model t=%0d: got %b want %b", t,
                         {pdm_clk, pdm_out, pcm_ready, underrun}, {e_clk, e_out, e_ready, e_under});
            else n_pass++;
        end
        ones = count_ones(256, 1279);
        exp1 = (val > 0) ? 768 : 256;
        n_checks++;
        if (ones < exp1 - 10 || ones > exp1 + 10)
            $display("FAIL density_1024 val=%0d: ones got %0d want %0d+/-10", val, ones, exp1);
        else n_pass++;
`ifdef PDM_TX_INTERP_EN
        exp2 = (val > 0) ? 80 : 48;
`else
        exp2 = (val > 0) ? 96 : 32;
`endif
        ones = count_ones(128, 255);
        n_checks++;
        if (ones < exp2 - 4 || ones > exp2 + 4)
            $display("FAIL density_first_slot val=%0d: ones got %0d want %0d+/-4", val, ones, exp2);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int   s[5];
        int   n_acc;
        int   und_t[$];
        logic rdy_pre;
        int   ones;
        real  expd;
        for (int j = 0; j < 5; j++) s[j] = int'($urandom_range(24000)) - 12000;
        do_reset();
        n_acc = 0;
        while (t < 6 * SLOT - 1) begin
            pcm_valid = (n_acc < 4);
            pcm_in = 16'(s[(n_acc < 4) ? n_acc : 0]);
            rdy_pre = pcm_ready;
            tick();
            if (rdy_pre && pcm_valid) begin
                $display("b2b: accept t=%0d sample=%0d", t, s[n_acc]);
                n_acc++;
            end
            if (underrun) und_t.push_back(t);
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== {e_clk, e_out, e_ready, e_under})
                $display("FAIL b2b_model t=%0d: got %b want %b", t,
                         {pdm_clk, pdm_out, pcm_ready, underrun}, {e_clk, e_out, e_ready, e_under});
            else n_pass++;
        end
        n_checks++;
        if (n_acc !== 4) $display("FAIL b2b_accepts: got %0d want 4", n_acc);
        else n_pass++;
        // Reassert valid so the accept lands on the sample_stb edge itself.
        pcm_valid = 1'b1;
        pcm_in = 16'(s[4]);
        tick();
        $display("b2b: accept-on-slot t=%0d sample=%0d", t, s[4]);
        if (underrun) und_t.push_back(t);
        n_checks++;
        if ({underrun, pcm_ready} !== 2'b10)
            $display("FAIL restart_on_slot t=%0d: und/rdy got %b want 10", t, {underrun, pcm_ready});
        else n_pass++;
        pcm_valid = 1'b0;
        while (t < 7 * SLOT + 5) begin
            tick();
            if (underrun) und_t.push_back(t);
            n_checks++;
            if ({pdm_clk, pdm_out, pcm_ready, underrun} !== {e_clk, e_out, e_ready, e_under})
                $display("FAIL b2b_model t=%0d: got %b want %b", t,
                         {pdm_clk, pdm_out, pcm_ready, underrun}, {e_clk, e_out, e_ready, e_under});
            else n_pass++;
            if (t == 7 * SLOT) begin
                n_checks++;
                if ({pcm_ready, underrun} !== 2'b10)
                    $display("FAIL held_consumed: rdy/und got %b want 10", {pcm_ready, underrun});
                else n_pass++;
            end
        end
        n_checks++;
        if (und_t.size() !== 2) $display("FAIL underrun_count: got %0d want 2", und_t.size());
        else n_pass++;
        if (und_t.size() >= 2) begin
            n_checks++;
            if (und_t[0] !== 5 * SLOT || und_t[1] !== 6 * SLOT)
                $display("FAIL underrun_times: got %0d,%0d want %0d,%0d",
                         und_t[0], und_t[1], 5 * SLOT, 6 * SLOT);
            else n_pass++;
        end
        ones = count_ones(640, 895);
        expd = 128.0 * (1.0 + real'(s[3]) / 32768.0);
        n_checks++;
        if (real'(ones) < expd - 5.0 || real'(ones) > expd + 5.0)
            $display("FAIL hold_last_density: ones got %0d want %0.1f+/-5", ones, expd);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_timing();
        test_zero();
        test_density(16384);
        test_density(-16384);
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
